// File: rtl/bif_bctl_cycle_seq.sv
// Purpose : BIF bus-cycle sequencer; turns re-timed bus strobes into latch strobes, grants and status.
// Latency : LATCH_ADDR one cycle after the BDAP50_n fall; pulses register one cycle after their transition.
// Backpres: none; the bus owns the pace, and WAIT_RDY is bounded by the ready-timeout counter.
//
// Ports:
//   OSC, CLEAR            clock and synchronous active-high reset
//   BDAP50_n ... BLOCK25_n re-timed active-low bus strobes (already synchronous to OSC)
//   CLR_PERR              clears the sticky parity flag
//   LATCH_ADDR/LATCH_DATA one-cycle datapath latch strobes
//   DIR_IN                direction captured in ADDR (1 = read toward CPU)
//   CYCLE_ACTIVE          any bus-cycle state
//   CYCLE_DONE/ABORT/BUS_TIMEOUT  one-cycle completion pulses
//   PARITY_ERR, REFGNT, SEMGNT    status and grants
//   STATE                 encoded state for debug
module bif_bctl_cycle_seq #(
    parameter int              TO_W           = 8,
    parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 8'd200
) (
    input  logic       OSC,
    input  logic       CLEAR,
    input  logic       BDAP50_n,
    input  logic       BDRY25_n,
    input  logic       BDRY50_n,
    input  logic       BINPUT50_n,
    input  logic       BPERR50_n,
    input  logic       REFRQ50_n,
    input  logic       SEMRQ50_n,
    input  logic       BLOCK25_n,
    input  logic       CLR_PERR,
    output logic       LATCH_ADDR,
    output logic       LATCH_DATA,
    output logic       DIR_IN,
    output logic       CYCLE_ACTIVE,
    output logic       CYCLE_DONE,
    output logic       ABORT,
    output logic       BUS_TIMEOUT,
    output logic       PARITY_ERR,
    output logic       REFGNT,
    output logic       SEMGNT,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_WAIT    = 3'd2,
        S_DATA    = 3'd3,
        S_END     = 3'd4,
        S_TMO     = 3'd5,
        S_REFRESH = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic              dap_prev_q;
    logic              pending_q, pending_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              dir_in_q;
    logic              perr_q;
    logic              semgnt_q;
    logic              done_q, abort_q, tmo_q;
    logic              dap_fall;

    assign dap_fall = dap_prev_q & ~BDAP50_n;

    // State register
    always_ff @(posedge OSC) begin
        if (CLEAR) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // A bus cycle (new or deferred behind a refresh) beats a refresh request.
                if (dap_fall || (pending_q && !BDAP50_n)) begin
                    state_d = S_ADDR;
                end else if (!REFRQ50_n && BDAP50_n && BLOCK25_n) begin
                    state_d = S_REFRESH;
                end
            end
            S_ADDR:  state_d = S_WAIT;
            S_WAIT: begin
                if (BDAP50_n) begin
                    state_d = S_IDLE;
                end else if (!BDRY25_n && !BDRY50_n) begin
                    // Both samples must agree so a one-cycle BDRY25_n glitch is ignored.
                    state_d = S_DATA;
                end else if (cnt_q == '0) begin
                    state_d = S_TMO;
                end
            end
            S_DATA:  state_d = S_END;
            S_END: begin
                if (BDAP50_n && BDRY50_n) state_d = S_IDLE;
            end
            S_TMO: begin
                if (BDAP50_n) state_d = S_IDLE;
            end
            S_REFRESH: begin
                if (REFRQ50_n) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counter and pending-cycle next state
    always_comb begin
        cnt_d     = cnt_q;
        pending_d = pending_q;
        if (state_q == S_ADDR) begin
            cnt_d = TIMEOUT_CYCLES;
        end else if (state_q == S_WAIT && state_d == S_WAIT && cnt_q != '0) begin
            cnt_d = cnt_q - TO_W'(1);
        end
        if (state_d == S_ADDR) begin
            pending_d = 1'b0;
        end else if (state_q == S_REFRESH && dap_fall) begin
            pending_d = 1'b1;
        end else if (state_q == S_IDLE && BDAP50_n) begin
            // The deferred cycle went away while refresh was running.
            pending_d = 1'b0;
        end
    end

    // Datapath and status registers
    always_ff @(posedge OSC) begin
        if (CLEAR) begin
            dap_prev_q <= 1'b1;
            pending_q  <= 1'b0;
            cnt_q      <= '0;
            dir_in_q   <= 1'b0;
            perr_q     <= 1'b0;
            semgnt_q   <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            dap_prev_q <= BDAP50_n;
            pending_q  <= pending_d;
            cnt_q      <= cnt_d;
            if (state_q == S_ADDR) begin
                dir_in_q <= ~BINPUT50_n;
            end
            // A new error in DATA outranks a simultaneous clear.
            if (state_q == S_DATA && !BPERR50_n) begin
                perr_q <= 1'b1;
            end else if (CLR_PERR) begin
                perr_q <= 1'b0;
            end
            if (SEMRQ50_n) begin
                semgnt_q <= 1'b0;
            end else if (state_q == S_IDLE && BLOCK25_n) begin
                semgnt_q <= 1'b1;
            end
            done_q  <= (state_q == S_END)  && (state_d == S_IDLE);
            abort_q <= (state_q == S_WAIT) && (state_d == S_IDLE);
            tmo_q   <= (state_q == S_WAIT) && (state_d == S_TMO);
        end
    end

    // Output decode
    always_comb begin
        LATCH_ADDR   = (state_q == S_ADDR);
        LATCH_DATA   = (state_q == S_DATA);
        CYCLE_ACTIVE = (state_q == S_ADDR) || (state_q == S_WAIT) || (state_q == S_DATA) ||
                       (state_q == S_END)  || (state_q == S_TMO);
        REFGNT       = (state_q == S_REFRESH);
        DIR_IN       = dir_in_q;
        CYCLE_DONE   = done_q;
        ABORT        = abort_q;
        BUS_TIMEOUT  = tmo_q;
        PARITY_ERR   = perr_q;
        SEMGNT       = semgnt_q;
        STATE        = state_q;
    end

endmodule

// File: tb/tb_bif_bctl_cycle_seq.sv
module tb_bif_bctl_cycle_seq;

    localparam int TMO = 4;

    logic OSC = 1'b0;
    logic CLEAR, BDAP50_n, BDRY25_n, BDRY50_n, BINPUT50_n, BPERR50_n;
    logic REFRQ50_n, SEMRQ50_n, BLOCK25_n, CLR_PERR;
    logic LATCH_ADDR, LATCH_DATA, DIR_IN, CYCLE_ACTIVE, CYCLE_DONE, ABORT;
    logic BUS_TIMEOUT, PARITY_ERR, REFGNT, SEMGNT;
    logic [2:0] STATE;
    logic [12:0] dut_vec;

    int checks = 0;
    int errors = 0;

    // Reference model state (phase numbers are the debug codes of the bus-cycle phases)
    int m_ph, m_wait;
    bit m_prev, m_pend, m_dir, m_perr, m_sem, m_done, m_abort, m_tmo;
    bit m_fall;
    int m_nph;

    bif_bctl_cycle_seq #(.TO_W(8), .TIMEOUT_CYCLES(8'd4)) dut (
        .OSC(OSC), .CLEAR(CLEAR), .BDAP50_n(BDAP50_n), .BDRY25_n(BDRY25_n),
        .BDRY50_n(BDRY50_n), .BINPUT50_n(BINPUT50_n), .BPERR50_n(BPERR50_n),
        .REFRQ50_n(REFRQ50_n), .SEMRQ50_n(SEMRQ50_n), .BLOCK25_n(BLOCK25_n),
        .CLR_PERR(CLR_PERR), .LATCH_ADDR(LATCH_ADDR), .LATCH_DATA(LATCH_DATA),
        .DIR_IN(DIR_IN), .CYCLE_ACTIVE(CYCLE_ACTIVE), .CYCLE_DONE(CYCLE_DONE),
        .ABORT(ABORT), .BUS_TIMEOUT(BUS_TIMEOUT), .PARITY_ERR(PARITY_ERR),
        .REFGNT(REFGNT), .SEMGNT(SEMGNT), .STATE(STATE)
    );

    always #5 OSC = ~OSC;

    assign dut_vec = {LATCH_ADDR, LATCH_DATA, DIR_IN, CYCLE_ACTIVE, CYCLE_DONE, ABORT,
                      BUS_TIMEOUT, PARITY_ERR, REFGNT, SEMGNT, STATE};

    // One clock of the behavioural model, from the inputs applied for the coming edge.
    task automatic model_step();
        if (CLEAR) begin
            m_ph = 0; m_wait = 0; m_prev = 1; m_pend = 0; m_dir = 0; m_perr = 0;
            m_sem = 0; m_done = 0; m_abort = 0; m_tmo = 0;
        end else begin
            m_fall = m_prev && !BDAP50_n;
            m_nph = m_ph;
            m_done = 0; m_abort = 0; m_tmo = 0;
            if (m_ph == 3 && !BPERR50_n) m_perr = 1;
            else if (CLR_PERR) m_perr = 0;
            if (SEMRQ50_n) m_sem = 0;
            else if (m_ph == 0 && BLOCK25_n) m_sem = 1;
            if (m_ph == 1) m_dir = !BINPUT50_n;
            case (m_ph)
                0: begin
                    if (m_fall || (m_pend && !BDAP50_n)) m_nph = 1;
                    else begin
                        if (BDAP50_n) m_pend = 0;
                        if (!REFRQ50_n && BDAP50_n && BLOCK25_n) m_nph = 6;
                    end
                end
                1: begin m_nph = 2; m_wait = 0; end
                2: begin
                    // m_wait = cycles already spent waiting; dwell is at most TMO+1 cycles
                    if (BDAP50_n) begin m_nph = 0; m_abort = 1; end
                    else if (!BDRY25_n && !BDRY50_n) m_nph = 3;
                    else if (m_wait == TMO) begin m_nph = 5; m_tmo = 1; end
                    else m_wait = m_wait + 1;
                end
                3: m_nph = 4;
                4: if (BDAP50_n && BDRY50_n) begin m_nph = 0; m_done = 1; end
                5: if (BDAP50_n) m_nph = 0;
                6: begin
                    if (m_fall) m_pend = 1;
                    if (REFRQ50_n) m_nph = 0;
                end
                default: m_nph = 0;
            endcase
            if (m_nph == 1) m_pend = 0;
            m_prev = BDAP50_n;
            m_ph = m_nph;
        end
    endtask

    function automatic logic [12:0] model_vec();
        logic [2:0] ph;
        ph = 3'(m_ph);
        return {m_ph == 1, m_ph == 3, m_dir, (m_ph >= 1 && m_ph <= 5), m_done, m_abort,
                m_tmo, m_perr, m_ph == 6, m_sem, ph};
    endfunction

    task automatic step();
        model_step();
        @(posedge OSC);
        #1;
    endtask

    task automatic idle_inputs();
        CLEAR = 0; BDAP50_n = 1; BDRY25_n = 1; BDRY50_n = 1; BINPUT50_n = 1;
        BPERR50_n = 1; REFRQ50_n = 1; SEMRQ50_n = 1; BLOCK25_n = 1; CLR_PERR = 0;
    endtask

    // Stimulus only: one complete read cycle with optional parity error / clear in DATA.
    task automatic bus_cycle(input bit perr, input bit clr);
        BDAP50_n = 0; BINPUT50_n = 0; step();        // ADDR
        step();                                      // WAIT_RDY
        BDRY25_n = 0; BDRY50_n = 0; step();          // DATA
        BPERR50_n = ~perr; CLR_PERR = clr; step();   // END
        BPERR50_n = 1; CLR_PERR = 0; BDAP50_n = 1; BDRY25_n = 1; BDRY50_n = 1;
        step();                                      // IDLE
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        CLEAR = 1;
        step();
        checks++; if (dut_vec !== 13'b0) begin errors++; $display("FAIL reset_outputs: got %b want 0", dut_vec); end
        BDAP50_n = 0;
        step();
        checks++; if (dut_vec !== 13'b0) begin errors++; $display("FAIL reset_hold: got %b want 0", dut_vec); end
        idle_inputs();
        step();
        checks++; if (STATE !== 3'd0) begin errors++; $display("FAIL reset_release_state: got %0d want 0", STATE); end
    endtask

    task automatic test_read_cycle();
        bit extra;
        extra = 0;
        idle_inputs();
        BDAP50_n = 0; BINPUT50_n = 0; step();   // cycle 1
        checks++; if (LATCH_ADDR !== 1'b1 || STATE !== 3'd1) begin errors++; $display("FAIL read_latch_addr: got la=%b st=%0d want la=1 st=1", LATCH_ADDR, STATE); end
        step();                                  // cycle 2
        checks++; if (DIR_IN !== 1'b1 || LATCH_ADDR !== 1'b0) begin errors++; $display("FAIL read_dir_in: got dir=%b la=%b want dir=1 la=0", DIR_IN, LATCH_ADDR); end
        for (int c = 3; c <= 5; c++) begin
            step();
            extra |= ABORT | BUS_TIMEOUT | LATCH_DATA | CYCLE_DONE;
        end
        BDRY25_n = 0; BDRY50_n = 0; step();      // cycle 6
        checks++; if (LATCH_DATA !== 1'b1 || STATE !== 3'd3) begin errors++; $display("FAIL read_latch_data: got ld=%b st=%0d want ld=1 st=3", LATCH_DATA, STATE); end
        step();                                  // cycle 7
        checks++; if (LATCH_DATA !== 1'b0 || STATE !== 3'd4) begin errors++; $display("FAIL read_end: got ld=%b st=%0d want ld=0 st=4", LATCH_DATA, STATE); end
        step();                                  // cycle 8
        step();                                  // cycle 9
        extra |= ABORT | BUS_TIMEOUT | CYCLE_DONE;
        BDAP50_n = 1; BDRY25_n = 1; BDRY50_n = 1; step();   // cycle 10
        checks++; if (CYCLE_DONE !== 1'b1 || STATE !== 3'd0) begin errors++; $display("FAIL read_done: got done=%b st=%0d want done=1 st=0", CYCLE_DONE, STATE); end
        extra |= ABORT | BUS_TIMEOUT;
        step();
        extra |= CYCLE_DONE | ABORT | BUS_TIMEOUT;
        checks++; if (extra !== 1'b0) begin errors++; $display("FAIL read_no_extra_pulse: got %b want 0", extra); end
    endtask

    task automatic test_timeout();
        bit early;
        early = 0;
        idle_inputs();
        BDAP50_n = 0; step();   // ADDR
        for (int c = 0; c <= TMO; c++) begin
            step();             // WAIT_RDY cycles, counter TMO..0
            if (STATE !== 3'd2 || BUS_TIMEOUT !== 1'b0) early = 1;
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL tmo_wait_dwell: got early=%b want 0", early); end
        step();
        checks++; if (BUS_TIMEOUT !== 1'b1 || STATE !== 3'd5) begin errors++; $display("FAIL tmo_pulse: got to=%b st=%0d want to=1 st=5", BUS_TIMEOUT, STATE); end
        step();
        checks++; if (BUS_TIMEOUT !== 1'b0 || STATE !== 3'd5) begin errors++; $display("FAIL tmo_hold: got to=%b st=%0d want to=0 st=5", BUS_TIMEOUT, STATE); end
        BDAP50_n = 1; step();
        checks++; if (STATE !== 3'd0 || CYCLE_DONE !== 1'b0) begin errors++; $display("FAIL tmo_exit: got st=%0d done=%b want st=0 done=0", STATE, CYCLE_DONE); end
        step();
        checks++; if (CYCLE_DONE !== 1'b0) begin errors++; $display("FAIL tmo_no_done: got %b want 0", CYCLE_DONE); end
    endtask

    task automatic test_abort_glitch();
        idle_inputs();
        BDAP50_n = 0; step(); step();        // ADDR, WAIT_RDY
        BDRY25_n = 0; step();
        checks++; if (LATCH_DATA !== 1'b0 || STATE !== 3'd2) begin errors++; $display("FAIL glitch_no_data: got ld=%b st=%0d want ld=0 st=2", LATCH_DATA, STATE); end
        BDRY25_n = 1; BDRY50_n = 0; step();
        checks++; if (LATCH_DATA !== 1'b0 || STATE !== 3'd2) begin errors++; $display("FAIL glitch_late50: got ld=%b st=%0d want ld=0 st=2", LATCH_DATA, STATE); end
        BDRY50_n = 1; BDAP50_n = 1; step();
        checks++; if (ABORT !== 1'b1 || STATE !== 3'd0) begin errors++; $display("FAIL abort_pulse: got ab=%b st=%0d want ab=1 st=0", ABORT, STATE); end
        step();
        checks++; if (ABORT !== 1'b0) begin errors++; $display("FAIL abort_single: got %b want 0", ABORT); end
    endtask

    task automatic test_refresh_pending();
        idle_inputs();
        REFRQ50_n = 0; step();
        checks++; if (REFGNT !== 1'b1 || STATE !== 3'd6) begin errors++; $display("FAIL ref_grant: got g=%b st=%0d want g=1 st=6", REFGNT, STATE); end
        BDAP50_n = 0; step();
        checks++; if (STATE !== 3'd6 || LATCH_ADDR !== 1'b0) begin errors++; $display("FAIL ref_defer: got st=%0d la=%b want st=6 la=0", STATE, LATCH_ADDR); end
        REFRQ50_n = 1; step();
        checks++; if (REFGNT !== 1'b0 || LATCH_ADDR !== 1'b0) begin errors++; $display("FAIL ref_release: got g=%b la=%b want g=0 la=0", REFGNT, LATCH_ADDR); end
        step();
        checks++; if (LATCH_ADDR !== 1'b1) begin errors++; $display("FAIL ref_pending_addr: got %b want 1", LATCH_ADDR); end
        step();
        BDAP50_n = 1; step(); step();
        checks++; if (STATE !== 3'd0) begin errors++; $display("FAIL ref_back_idle: got %0d want 0", STATE); end
    endtask

    task automatic test_parity_sem();
        idle_inputs();
        SEMRQ50_n = 0; step();
        checks++; if (SEMGNT !== 1'b1) begin errors++; $display("FAIL sem_grant: got %b want 1", SEMGNT); end
        bus_cycle(1, 0);
        checks++; if (PARITY_ERR !== 1'b1) begin errors++; $display("FAIL perr_set: got %b want 1", PARITY_ERR); end
        checks++; if (SEMGNT !== 1'b1) begin errors++; $display("FAIL sem_hold: got %b want 1", SEMGNT); end
        bus_cycle(0, 0);
        checks++; if (PARITY_ERR !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %b want 1", PARITY_ERR); end
        bus_cycle(1, 1);
        checks++; if (PARITY_ERR !== 1'b1) begin errors++; $display("FAIL perr_set_wins: got %b want 1", PARITY_ERR); end
        CLR_PERR = 1; step();
        CLR_PERR = 0;
        checks++; if (PARITY_ERR !== 1'b0) begin errors++; $display("FAIL perr_clear: got %b want 0", PARITY_ERR); end
        SEMRQ50_n = 1; step();
        checks++; if (SEMGNT !== 1'b0) begin errors++; $display("FAIL sem_drop: got %b want 0", SEMGNT); end
    endtask

    task automatic test_mid_reset();
        idle_inputs();
        SEMRQ50_n = 0; step();
        BDAP50_n = 0; BINPUT50_n = 0; step(); step(); step();   // ADDR, WAIT cnt=4, WAIT cnt=3
        checks++; if (STATE !== 3'd2 || SEMGNT !== 1'b1) begin errors++; $display("FAIL mrst_pre: got st=%0d sem=%b want st=2 sem=1", STATE, SEMGNT); end
        CLEAR = 1; BDAP50_n = 1; SEMRQ50_n = 1; step();
        checks++; if (dut_vec !== 13'b0) begin errors++; $display("FAIL mrst_outputs: got %b want 0", dut_vec); end
        CLEAR = 0; step();
        BDAP50_n = 0; BINPUT50_n = 1; step();
        checks++; if (LATCH_ADDR !== 1'b1 || STATE !== 3'd1) begin errors++; $display("FAIL mrst_fresh: got la=%b st=%0d want la=1 st=1", LATCH_ADDR, STATE); end
        step();
        checks++; if (DIR_IN !== 1'b0 || STATE !== 3'd2) begin errors++; $display("FAIL mrst_dir: got dir=%b st=%0d want dir=0 st=2", DIR_IN, STATE); end
        BDAP50_n = 1; step(); step();
    endtask

    task automatic test_random();
        bit prev25;
        int bad;
        bad = 0;
        idle_inputs();
        prev25 = 1;
        for (int i = 0; i < 3000; i++) begin
            CLEAR = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) == 0) BDAP50_n = ~BDAP50_n;
            BDRY25_n = ($urandom_range(0, 5) != 0);
            BDRY50_n = ($urandom_range(0, 4) != 0) ? prev25 : 1'($urandom_range(0, 1));
            prev25 = BDRY25_n;
            BINPUT50_n = 1'($urandom_range(0, 1));
            BPERR50_n = ($urandom_range(0, 4) != 0);
            CLR_PERR = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 11) == 0) REFRQ50_n = ~REFRQ50_n;
            if ($urandom_range(0, 19) == 0) SEMRQ50_n = ~SEMRQ50_n;
            BLOCK25_n = ($urandom_range(0, 6) != 0);
            step();
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                if (bad < 10) $display("FAIL rand_cycle%0d: got %b want %b", i, dut_vec, model_vec());
                bad++;
            end
        end
        idle_inputs();
        step();
    endtask

    initial begin
        idle_inputs();
        CLEAR = 1;
        test_reset();
        test_read_cycle();
        test_timeout();
        test_abort_glitch();
        test_refresh_pending();
        test_parity_sem();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bif_bctl_cycle_seq.md
Name: bif_bctl_cycle_seq

Overview:
- Bus-cycle sequencer directly downstream of the BIF synchronizer stage.
- Consumes the 25/50 ns re-timed bus strobes (BDAP50_n, BDRY25_n/BDRY50_n, BINPUT50_n, BPERR50_n, REFRQ50_n, SEMRQ50_n, BLOCK25_n).
- Generates single-cycle address/data latch strobes, direction, timeout, parity-error and refresh/semaphore grant signals for the BIF datapath.
- All inputs are already synchronous to OSC; no further synchronization inside.

Parameters:
- TO_W, 8, width of the ready-timeout counter.
- TIMEOUT_CYCLES, 8'd200, counter load value; max WAIT_RDY dwell is TIMEOUT_CYCLES+1 cycles.

Ports:
- OSC  in  1  system clock, all state on rising edge.
- CLEAR  in  1  reset; one clock, synchronous, active-high.
- BDAP50_n  in  1  address present, active-low.
- BDRY25_n  in  1  data ready, first sample, active-low.
- BDRY50_n  in  1  data ready, second sample, active-low.
- BINPUT50_n  in  1  low means the cycle is a read toward the CPU.
- BPERR50_n  in  1  parity error, active-low.
- REFRQ50_n  in  1  refresh request, active-low.
- SEMRQ50_n  in  1  semaphore request, active-low.
- BLOCK25_n  in  1  bus lock, active-low.
- CLR_PERR  in  1  clears PARITY_ERR.
- LATCH_ADDR  out  1  one-cycle address latch strobe.
- LATCH_DATA  out  1  one-cycle data latch strobe.
- DIR_IN  out  1  captured direction; 1 = read.
- CYCLE_ACTIVE  out  1  high in ADDR, WAIT_RDY, DATA, END, TMO.
- CYCLE_DONE  out  1  one-cycle pulse on END→IDLE.
- ABORT  out  1  one-cycle pulse on WAIT_RDY→IDLE.
- BUS_TIMEOUT  out  1  one-cycle pulse on WAIT_RDY→TMO.
- PARITY_ERR  out  1  sticky parity error flag.
- REFGNT  out  1  refresh grant.
- SEMGNT  out  1  semaphore grant.
- STATE  out  3  encoded state for debug.

Behaviour:
- Reset values: CLEAR=1 forces state IDLE. All outputs 0, counter 0, dap_prev=1, pending=0. Reset applies mid-operation, including in REFRESH and TMO.
- Edge detect: dap_prev <= BDAP50_n every cycle. dap_fall = dap_prev & ~BDAP50_n.
- Outputs are Moore/registered: each strobe is high during the cycle the FSM occupies the named state. State encoding: IDLE=0, ADDR=1, WAIT_RDY=2, DATA=3, END=4, TMO=5, REFRESH=6.
- IDLE:
  - dap_fall or pending → ADDR. This wins over refresh in the same cycle. pending is cleared on entry to ADDR.
  - Else REFRQ50_n=0 & BDAP50_n=1 & BLOCK25_n=1 → REFRESH.
- ADDR (1 cycle):
  - LATCH_ADDR=1.
  - DIR_IN <= ~BINPUT50_n; DIR_IN holds until the next ADDR.
  - cnt <= TIMEOUT_CYCLES.
  - → WAIT_RDY.
- WAIT_RDY, priority from highest to lowest:
  - BDAP50_n=1 → IDLE, with an ABORT pulse.
  - BDRY25_n=0 & BDRY50_n=0 (two consistent samples) → DATA.
  - cnt=0 → TMO, with a BUS_TIMEOUT pulse.
  - Else cnt <= cnt-1. Counter saturates at 0 and never wraps.
- DATA (1 cycle):
  - LATCH_DATA=1.
  - If BPERR50_n=0, PARITY_ERR <= 1.
  - → END.
- END: wait until BDAP50_n=1 & BDRY50_n=1, then → IDLE with a CYCLE_DONE pulse.
- TMO: wait until BDAP50_n=1, then → IDLE. No CYCLE_DONE pulse.
- REFRESH:
  - REFGNT=1 while REFRQ50_n=0.
  - A dap_fall here sets pending=1.
  - REFRQ50_n=1 → IDLE. If pending=1 and BDAP50_n=0, IDLE goes to ADDR on the next cycle. If BDAP50_n=1 at IDLE entry, pending clears.
- PARITY_ERR: set in DATA, cleared by CLR_PERR. A set and a clear in the same cycle leaves it set.
- SEMGNT:
  - Set when SEMRQ50_n=0 & BLOCK25_n=1 & state=IDLE.
  - Cleared when SEMRQ50_n=1, in any state.
  - Holds across bus cycles.
- A glitch-free response is required for a single-cycle BDRY25_n low with BDRY50_n high: no DATA entry.

Test Plan:
- Read cycle: BDAP50_n falls at cycle 0, BINPUT50_n=0, BDRY pair low at cycle 5 → LATCH_ADDR at cycle 1, DIR_IN=1, LATCH_DATA at cycle 6. BDAP50_n high at cycle 9 gives CYCLE_DONE at cycle 10, and no other pulses.
- Timeout: TIMEOUT_CYCLES=4, BDAP50_n held low, BDRY never asserted → BUS_TIMEOUT 5 cycles after WAIT_RDY entry and STATE=5 until BDAP50_n rises, then IDLE. CYCLE_DONE stays 0.
- Abort and glitch: a single-cycle BDRY25_n low gives no LATCH_DATA. BDAP50_n then rises in WAIT_RDY → ABORT pulse, STATE=0.
- Refresh with pending cycle: REFRQ50_n low in IDLE → REFGNT=1. BDAP50_n falls during REFRESH, then REFRQ50_n rises → REFGNT=0, then ADDR with LATCH_ADDR on the second cycle after REFRQ50_n rises.
- Parity and semaphore: BPERR50_n=0 during DATA → PARITY_ERR=1, which persists through the next clean cycle. CLR_PERR together with a parity-error DATA leaves it 1; CLR_PERR alone clears it. SEMRQ50_n low in IDLE → SEMGNT=1; it holds through a full read cycle and drops the cycle after SEMRQ50_n rises.
- Mid-cycle reset: CLEAR=1 during WAIT_RDY with cnt=3 → next cycle STATE=0, all outputs 0. A new BDAP50_n fall after reset is treated as a fresh cycle.
